// File: rtl/add_serial_pkg.sv
// add_serial_pkg
// Shared definitions for the chunk-serial adder:
//   state_t    - controller states (IDLE, RUN, DONE)
//   calc_idx_w - width of the chunk index counter (at least one bit)
package add_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-chunk configuration still needs a one-bit index register.
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_serial_fa_chunk.sv
// fa_chunk
// Combinational CHUNK-bit adder slice used by add_serial.
// Ports:
//   a, b  [CHUNK-1:0] in  - operand chunks
//   cin               in  - carry into bit 0 of the chunk
//   sum   [CHUNK-1:0] out - a + b + cin, truncated to CHUNK bits
//   cout              out - carry out of the chunk MSB
//   cmsb              out - carry into the chunk MSB (for signed overflow)
module fa_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum   = total[CHUNK-1:0];
    assign cout  = total[CHUNK];
    // The MSB sum bit is a ^ b ^ carry_in, so the carry into the MSB is
    // recovered from it; this also works when CHUNK is 1.
    assign cmsb  = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/add_serial.sv
// add_serial
// Multi-cycle adder: WIDTH-bit operands are added CHUNK bits per clock,
// least significant chunk first, using a single fa_chunk slice.
//
// Handshake: an input transfer happens on a rising edge where in_valid and
// in_ready are both 1; an output transfer happens on a rising edge where
// out_valid and out_ready are both 1. in_ready is 1 only in IDLE and
// out_valid only in DONE, so exactly one operation is in flight at a time
// and nothing offered while busy is queued.
//
// Ports:
//   clk, nrst            - clock (rising edge), async active-low reset
//   in_valid / in_ready  - operand handshake
//   A, B [WIDTH-1:0], Cin - operands and carry-in
//   out_valid / out_ready - result handshake
//   S [WIDTH-1:0]        - A + B + Cin mod 2^WIDTH
//   Cout                 - carry out of bit WIDTH-1
//   ovf                  - two's-complement overflow
//   fsm_state [1:0]      - current controller state (state_t encoding)
module add_serial
    import add_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic [1:0]       fsm_state
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = calc_idx_w(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if (CHUNK < 1 || N < 1 || (N * CHUNK) != WIDTH) begin : g_bad_params
            $error("add_serial: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] fa_sum;
    logic             fa_cout;
    logic             fa_cmsb;

    // Chunk selection by comparing idx against each constant position keeps
    // every part-select index static.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    fa_chunk #(
        .CHUNK(CHUNK)
    ) u_fa (
        .a   (a_chunk),
        .b   (b_chunk),
        .cin (carry),
        .sum (fa_sum),
        .cout(fa_cout),
        .cmsb(fa_cmsb)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= B;
                        // Chunk 0 always starts from the latched carry-in.
                        carry      <= Cin;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == IDX_W'(i)) begin
                            s_q[i*CHUNK +: CHUNK] <= fa_sum;
                        end
                    end
                    carry <= fa_cout;
                    if (idx == LAST_IDX) begin
                        cout_q      <= fa_cout;
                        ovf_q       <= fa_cmsb ^ fa_cout;
                        idx         <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign ovf       = ovf_q;
    assign fsm_state = state;

endmodule

// File: doc/add_serial.md
ADD_SERIAL -- requirements
Module: add_serial

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 4, meaning bits added per clock cycle.
REQ-003 The module SHALL have port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-004 The module SHALL have port nrst, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1, meaning operands A, B and Cin are presented.
REQ-006 The module SHALL have port in_ready, output, 1, meaning the block can accept operands.
REQ-007 The module SHALL have ports A and B, input, WIDTH each, meaning unsigned/two's-complement operands.
REQ-008 The module SHALL have port Cin, input, 1, meaning carry-in.
REQ-009 The module SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-010 The module SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-011 The module SHALL have port S, output, WIDTH, meaning the sum A+B+Cin mod 2^WIDTH.
REQ-012 The module SHALL have port Cout, output, 1, meaning carry out of bit WIDTH-1.
REQ-013 The module SHALL have port ovf, output, 1, meaning two's-complement overflow (carry into MSB XOR Cout).

Function
REQ-014 WIDTH SHALL be an integer multiple of CHUNK, with N = WIDTH/CHUNK >= 1; elaboration SHALL fail otherwise.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE: in_ready=1, out_valid=0; on an edge with in_valid=1, A, B and Cin SHALL be latched, the chunk index cleared to 0, and the state SHALL move to RUN.
REQ-017 In RUN: in_ready=0; each cycle SHALL add chunk idx of A, B plus the running carry, write S[idx*CHUNK +: CHUNK], update the carry and increment idx.
REQ-018 When chunk N-1 is processed, Cout and ovf SHALL be registered and the state SHALL move to DONE.
REQ-019 Latency: if operands are accepted at edge k, out_valid SHALL first be 1 after edge k+N.
REQ-020 In DONE: out_valid=1; S, Cout and ovf SHALL be held stable until an edge with out_ready=1, after which the state SHALL move to IDLE.
REQ-021 in_valid SHALL be ignored outside IDLE; no operand is queued.
REQ-022 S, Cout and ovf SHALL be registered outputs; their values outside DONE are don't-care for checking but SHALL be free of X after reset.
REQ-023 The carry chain SHALL NOT wrap: the carry into chunk 0 is always the latched Cin.

Reset
REQ-024 When nrst=0, asynchronously: the state SHALL be IDLE, idx=0, the carry=0, S=0, Cout=0, ovf=0, out_valid=0 and in_ready=1.
REQ-025 Reset asserted during RUN or DONE SHALL abandon the operation, with no result ever presented for it.

Structure
REQ-026 The package add_serial_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE).
REQ-027 One sub-module, fa_chunk, SHALL be used: a parametrised CHUNK-bit combinational adder with outputs sum, cout and carry-into-MSB (used for ovf).
REQ-028 The total RTL SHALL target 120-400 lines.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-029 Stimulus: A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, ovf=0, with out_valid rising exactly 4 edges after accept.
REQ-030 Stimulus: A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Cout=0, ovf=1; and A=0x8000, B=0x8000, Cin=1 -> S=0x0001, Cout=1, ovf=1.
REQ-031 Stimulus: out_ready held 0 for 3 cycles in DONE, with in_valid=1 and new operands toggling -> S, Cout and ovf stable, in_ready=0, and the new operands not accepted.
REQ-032 Stimulus: nrst pulsed low at the 2nd RUN cycle -> immediate IDLE, in_ready=1, outputs 0, and no out_valid; the next transaction 0x1234+0x4321 gives 0x5555.
REQ-033 Stimulus: WIDTH=4, CHUNK=1, exhaustive over all 512 combinations of A, B and Cin -> {Cout,S} equal to A+B+Cin for every combination, and ovf matching the signed reference.
REQ-034 Stimulus: back-to-back transactions with out_ready=1 and in_valid=1 held -> one result every N+2 cycles, none dropped or duplicated.
